gftt_nms: RTL
=============

# gftt_nms

Consumer of the min-eigenvalue score stream produced by the GFTT eigenvalue stage. It performs 3x3 non-maximum suppression on the raster-ordered 16-bit score stream and applies a threshold. Each surviving local maximum is emitted as a keypoint record (x, y, score) through a valid/ready FIFO toward the feature-descriptor / AXI write-back logic. It is the reader side of the (dout, vout) score interface.

## Interface
- WDT_MAX, 2048: maximum row width in pixels; sets line-buffer depth.
- FIFO_DEPTH, 16: keypoint FIFO entries, power of two.
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- wdt_m1  in  11  row width minus one; static while a frame is running.
- thr  in  16  score threshold (u16, same scaling as the score stream); static per frame.
- start  in  1  one-cycle pulse at frame start; clears position, FIFO, statistics.
- enb  in  1  block enable; when low, vin is ignored.
- din  in  16  eigenvalue score, raster order.
- vin  in  1  din valid qualifier; no backpressure upstream.
- kp_x  out  11  keypoint column.
- kp_y  out  11  keypoint row.
- kp_score  out  16  keypoint score.
- kp_valid  out  1  FIFO head valid.
- kp_ready  in  1  consumer accepts head when kp_valid & kp_ready.
- kp_count  out  16  keypoints accepted into FIFO this frame, saturating at 0xFFFF.
- kp_ovf  out  1  sticky: a keypoint was dropped because the FIFO was full.

## Operation
- Position counters col/row (11 b) advance on each vin & enb; col wraps from wdt_m1 to 0 and increments row; row saturates at 2047.
- Two line buffers (WDT_MAX x 16 b, synchronous read) hold rows row-1 and row-2; a 3x3 window register shifts one column per accepted pixel.
- Window centre is pixel (col-1, row-1) of the current input (col, row). It is evaluated only when 2 <= col <= wdt_m1 and row >= 2. Consequences: row 0, column 0, column wdt_m1 and the last frame row never produce keypoints.
- Keypoint condition, all required: centre >= thr; centre strictly greater than the 4 neighbours above and to the left (NW, N, NE, W); centre >= the 4 neighbours below and to the right (E, SW, S, SE). This tie-break yields exactly one keypoint per equal-valued plateau pair.
- Detected keypoint {x=col-1, y=row-1, score} is pushed into the FIFO. If the FIFO is full, the record is dropped, kp_ovf is set, and kp_count does not increment.
- start (has priority over a same-cycle vin): col/row <= 0; FIFO flushed; kp_count <= 0; kp_ovf <= 0; pipeline valid bits cleared. Line-buffer contents are not cleared; they are masked by the row >= 2 rule.
- enb low: no counter advance, no detection; FIFO keeps draining to the consumer.
- Push and pop in the same cycle on a full FIFO: the pop frees the slot and the push succeeds, no overflow.

## Timing
- Reset values: kp_x, kp_y, kp_score = 0; kp_valid = 0; kp_count = 0; kp_ovf = 0; all internal counters and valid pipes = 0.
- Pipeline stages: cycle t = vin of pixel (c+1, r+1); t+1 = line-buffer read and window shift; t+2 = comparisons registered; t+3 = FIFO push.
- FIFO is first-word-fall-through: kp_valid = 1 at t+4 when the FIFO was empty, and the outputs hold stable until the handshake.
- Throughput: one pixel per cycle sustained, with vin allowed on consecutive cycles.
- Once start is sampled, any keypoint still in the pipeline is discarded.

## Structure
- Shared package gftt_pkg holds: score width 16, coordinate width 11, keypoint record typedef (38 b: x, y, score), FIFO_DEPTH default.
- Sub-module gftt_kp_fifo: synchronous FWFT FIFO with flush, full/empty, simultaneous push/pop.
- Line buffers are inferred RAMs inside gftt_nms.

## Test plan
- Single peak: wdt_m1=15, thr=0x0100, all zeros except (5,3)=0x1000 -> exactly one keypoint (5,3,0x1000), with kp_valid 4 cycles after the vin of pixel (6,4); kp_count=1.
- Plateau: (4,2)=(5,2)=0x0800, other pixels 0 -> only (4,2) reported. Threshold edge: peak 0x00FF with thr=0x0100 -> none; peak 0x0100 -> reported.
- Borders: peaks at (0,3), (15,3), (5,0) and in the last frame row -> no keypoints, kp_count=0.
- Overflow: kp_ready=0, 20 isolated peaks -> 16 records held, kp_count=16, kp_ovf=1. Release kp_ready -> 16 records drain in raster order. Next start clears kp_ovf and kp_count.
- Backpressure with same-cycle push/pop on a full FIFO: kp_ready toggled randomly -> no loss and no duplicates, kp_ovf stays 0.
- start mid-row and enb gaps: start asserted at (7,5) followed by a fresh frame -> no stale keypoints. enb low for 10 cycles with vin high -> identical results to the gap-free stream.

Source files
------------

// File: rtl/gftt_pkg.sv
// Shared definitions for the GFTT keypoint back end.
//   SCORE_W        : width of the min-eigenvalue score stream
//   COORD_W        : width of pixel column/row coordinates
//   FIFO_DEPTH_DEF : default keypoint FIFO depth (power of two)
//   kp_t           : keypoint record {x, y, score}, 38 bits
package gftt_pkg;

    localparam int SCORE_W        = 16;
    localparam int COORD_W        = 11;
    localparam int FIFO_DEPTH_DEF = 16;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [SCORE_W-1:0] score;
    } kp_t;

    localparam int KP_W = $bits(kp_t);

endpackage

// File: rtl/gftt_kp_fifo.sv
// First-word-fall-through keypoint FIFO with synchronous flush.
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : empties the FIFO (wins over push and pop)
//   push, wdata : write request and record
//   accepted    : push was stored this cycle
//   dropped     : push was refused because the FIFO was full
//   pop_ready   : consumer takes the head when valid is high
//   rdata       : head record (zero while empty)
//   valid       : head record present
module gftt_kp_fifo
    import gftt_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            push,
    input  logic [KP_W-1:0] wdata,
    output logic            accepted,
    output logic            dropped,
    input  logic            pop_ready,
    output logic [KP_W-1:0] rdata,
    output logic            valid
);

    localparam int AW = $clog2(DEPTH);

    logic [KP_W-1:0] mem [DEPTH];
    logic [AW:0]     wr_ptr_reg;
    logic [AW:0]     rd_ptr_reg;
    logic            full;
    logic            pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign valid = (wr_ptr_reg != rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop   = valid && pop_ready && !flush;

    // A pop in the same cycle frees the slot, so a push on full still lands.
    assign accepted = push && !flush && (!full || pop);
    assign dropped  = push && !flush && full && !pop;

    assign rdata = valid ? mem[rd_ptr_reg[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (accepted) begin
            mem[wr_ptr_reg[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (accepted) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)      rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/gftt_nms.sv
// 3x3 non-maximum suppression plus threshold on a raster score stream.
// Surviving local maxima are queued as {x, y, score} keypoint records.
//   clk, rst_n          : clock, asynchronous active-low reset
//   wdt_m1              : row width minus one (static per frame)
//   thr                 : score threshold (static per frame)
//   start               : frame start pulse; clears position, FIFO, stats
//   enb, din, vin       : input score stream, accepted when vin & enb
//   kp_x, kp_y, kp_score, kp_valid, kp_ready : keypoint FWFT output
//   kp_count            : keypoints queued this frame, saturating
//   kp_ovf              : sticky, a keypoint was lost to a full FIFO
module gftt_nms
    import gftt_pkg::*;
#(
    parameter int WDT_MAX    = 2048,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [COORD_W-1:0]  wdt_m1,
    input  logic [SCORE_W-1:0]  thr,
    input  logic                start,
    input  logic                enb,
    input  logic [SCORE_W-1:0]  din,
    input  logic                vin,
    output logic [COORD_W-1:0]  kp_x,
    output logic [COORD_W-1:0]  kp_y,
    output logic [SCORE_W-1:0]  kp_score,
    output logic                kp_valid,
    input  logic                kp_ready,
    output logic [15:0]         kp_count,
    output logic                kp_ovf
);

    localparam int LB_AW = $clog2(WDT_MAX);

    logic accept;
    assign accept = vin && enb && !start;

    // ---------------- position counters ----------------
    logic [COORD_W-1:0] col_reg;
    logic [COORD_W-1:0] row_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (start) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (accept) begin
            if (col_reg == wdt_m1) begin
                col_reg <= '0;
                if (row_reg != '1) row_reg <= row_reg + 11'd1;
            end else begin
                col_reg <= col_reg + 11'd1;
            end
        end
    end

    // ---------------- line buffers ----------------
    // lb1 holds row-1, lb2 holds row-2. lb1 is read before being overwritten
    // with the new pixel; the old lb1 value migrates into lb2 one cycle later.
    logic [SCORE_W-1:0] lb1 [WDT_MAX];
    logic [SCORE_W-1:0] lb2 [WDT_MAX];
    logic [SCORE_W-1:0] rd1_reg;
    logic [SCORE_W-1:0] rd2_reg;

    logic               s1_valid_reg;
    logic               s1_eval_reg;
    logic [COORD_W-1:0] col_s1_reg;
    logic [COORD_W-1:0] cx_s1_reg;
    logic [COORD_W-1:0] cy_s1_reg;
    logic [SCORE_W-1:0] din_s1_reg;

    always_ff @(posedge clk) begin
        if (accept) begin
            rd1_reg                <= lb1[col_reg[LB_AW-1:0]];
            lb1[col_reg[LB_AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rd2_reg <= lb2[col_reg[LB_AW-1:0]];
        end
        if (s1_valid_reg) begin
            lb2[col_s1_reg[LB_AW-1:0]] <= rd1_reg;
        end
    end

    // ---------------- stage 1: pixel capture ----------------
    // The window centre is the pixel one column left and one row up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_eval_reg  <= 1'b0;
            col_s1_reg   <= '0;
            cx_s1_reg    <= '0;
            cy_s1_reg    <= '0;
            din_s1_reg   <= '0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_eval_reg <= (col_reg >= 11'd2) && (row_reg >= 11'd2);
                col_s1_reg  <= col_reg;
                cx_s1_reg   <= col_reg - 11'd1;
                cy_s1_reg   <= row_reg - 11'd1;
                din_s1_reg  <= din;
            end
        end
    end

    // ---------------- 3x3 window ----------------
    // win[r][c]: r=0 is row-2 (north), r=2 is the current row (south);
    // c=0 is the west column, c=2 the newest (east) column.
    logic [SCORE_W-1:0] win [3][3];
    logic [SCORE_W-1:0] new_col [3];

    always_comb begin
        new_col[0] = rd2_reg;
        new_col[1] = rd1_reg;
        new_col[2] = din_s1_reg;
    end

    logic               s2_valid_reg;
    logic [COORD_W-1:0] cx_s2_reg;
    logic [COORD_W-1:0] cy_s2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
            s2_valid_reg <= 1'b0;
            cx_s2_reg    <= '0;
            cy_s2_reg    <= '0;
        end else begin
            if (s1_valid_reg) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                    win[r][2] <= new_col[r];
                end
                cx_s2_reg <= cx_s1_reg;
                cy_s2_reg <= cy_s1_reg;
            end
            s2_valid_reg <= !start && s1_valid_reg && s1_eval_reg;
        end
    end

    // ---------------- stage 2: comparisons ----------------
    // Neighbours 0..3 (NW, N, NE, W) must be strictly smaller, 4..7
    // (E, SW, S, SE) only not larger: an equal pair keeps its raster-first pixel.
    logic [SCORE_W-1:0] centre;
    logic [SCORE_W-1:0] nbr [8];
    logic [7:0]         beats;
    logic               is_peak;

    always_comb begin
        centre = win[1][1];
        nbr[0] = win[0][0];
        nbr[1] = win[0][1];
        nbr[2] = win[0][2];
        nbr[3] = win[1][0];
        nbr[4] = win[1][2];
        nbr[5] = win[2][0];
        nbr[6] = win[2][1];
        nbr[7] = win[2][2];
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cmp
            if (gi < 4) begin : g_strict
                assign beats[gi] = (centre > nbr[gi]);
            end else begin : g_loose
                assign beats[gi] = (centre >= nbr[gi]);
            end
        end
    endgenerate

    assign is_peak = (centre >= thr) && (&beats);

    logic det_valid_reg;
    kp_t  det_rec_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_valid_reg <= 1'b0;
            det_rec_reg   <= '0;
        end else begin
            det_valid_reg <= !start && s2_valid_reg && is_peak;
            if (s2_valid_reg) begin
                det_rec_reg <= '{x: cx_s2_reg, y: cy_s2_reg, score: centre};
            end
        end
    end

    // ---------------- stage 3: FIFO push ----------------
    logic            fifo_accepted;
    logic            fifo_dropped;
    logic [KP_W-1:0] fifo_rdata;
    kp_t             head;

    gftt_kp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (start),
        .push      (det_valid_reg),
        .wdata     (det_rec_reg),
        .accepted  (fifo_accepted),
        .dropped   (fifo_dropped),
        .pop_ready (kp_ready),
        .rdata     (fifo_rdata),
        .valid     (kp_valid)
    );

    assign head     = fifo_rdata;
    assign kp_x     = head.x;
    assign kp_y     = head.y;
    assign kp_score = head.score;

    // ---------------- statistics ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kp_count <= '0;
            kp_ovf   <= 1'b0;
        end else if (start) begin
            kp_count <= '0;
            kp_ovf   <= 1'b0;
        end else begin
            if (fifo_accepted && kp_count != 16'hFFFF) kp_count <= kp_count + 16'd1;
            if (fifo_dropped) kp_ovf <= 1'b1;
        end
    end

endmodule
